// File: rtl/uart_tx_drain.sv
// uart_tx_drain: UART transmitter that drains an upstream byte FIFO.
// Pops one byte whenever the FIFO is non-empty and the line is free. Each byte
// goes out as a start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop
// bits. Frames run back-to-back while the FIFO stays non-empty.
//
// Ports:
//   clock        system clock, posedge
//   reset        synchronous, active-high
//   fifo_ready_i FIFO non-empty
//   fifo_data_i  head-of-FIFO byte, valid while fifo_ready_i is high
//   fifo_read_o  pop strobe to the FIFO (combinational)
//   tx_o         serial line, idles high (registered)
//   busy_o       frame in progress (registered)
module uart_tx_drain #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fifo_ready_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  output logic                 fifo_read_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int unsigned BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int unsigned BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_d, busy_d;
  logic                 baud_last, last_cycle, pop;

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_o    <= tx_d;
      busy_o  <= busy_d;
    end
  end

  // Next-state, pop strobe and next outputs
  always_comb begin
    baud_last  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    last_cycle = (state_q == STOP) && (bit_q == BIT_W'(STOP_BITS - 1)) && baud_last;
    pop        = fifo_ready_i && !reset && ((state_q == IDLE) || last_cycle);

    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          state_d = START;
          shift_d = fifo_data_i;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          if (last_cycle) begin
            bit_d = '0;
            // A pop on the final stop cycle chains straight into the next start bit
            if (pop) begin
              state_d = START;
              shift_d = fifo_data_i;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered line level follows the state being entered
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);

    fifo_read_o = pop;
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: two instances (1 and 2 stop bits) fed from queue-based
// FIFO models; expected line level, busy and pop come from a frame-position model.
module tb_uart_tx_drain;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DB    = 8;
  localparam int          FLEN1 = (1 + DB + 1) * CPB;
  localparam int          FLEN2 = (1 + DB + 2) * CPB;

  logic       clock = 1'b0;
  logic       reset;
  logic       rdy1, rdy2;
  logic [7:0] d1, d2;
  logic       rd1, rd2, tx1, tx2, busy1, busy2;

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .fifo_ready_i(rdy1), .fifo_data_i(d1),
    .fifo_read_o(rd1), .tx_o(tx1), .busy_o(busy1)
  );

  uart_tx_drain #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .fifo_ready_i(rdy2), .fifo_data_i(d2),
    .fifo_read_o(rd2), .tx_o(tx2), .busy_o(busy2)
  );

  always #5 clock = ~clock;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic       en1, en2;
  int         rem1, rem2;
  logic [7:0] fb1, fb2;
  int         pops1, pops2;
  int         checks, errors;

  // Expected line level for a frame with 'rem' cycles left (0 = idle)
  function automatic logic exp_tx(input int rem, input logic [7:0] b, input int flen);
    int p, k;
    if (rem == 0) return 1'b1;
    p = flen - rem;
    k = p / CPB;
    if (k == 0) return 1'b0;
    if (k <= DB) return b[k-1];
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    rdy1 = en1 && (q1.size() > 0);
    d1   = (q1.size() > 0) ? q1[0] : 8'($urandom);
    rdy2 = en2 && (q2.size() > 0);
    d2   = (q2.size() > 0) ? q2[0] : 8'($urandom);
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge
  task automatic step();
    logic p1, p2;
    drive();
    @(negedge clock);
    p1 = !reset && rdy1 && (rem1 <= 1);
    p2 = !reset && rdy2 && (rem2 <= 1);
    check("pop1", rd1, p1);
    check("tx1", tx1, exp_tx(rem1, fb1, FLEN1));
    check("busy1", busy1, rem1 != 0);
    check("pop2", rd2, p2);
    check("tx2", tx2, exp_tx(rem2, fb2, FLEN2));
    check("busy2", busy2, rem2 != 0);
    if (rd1 === 1'b1) pops1++;
    if (rd2 === 1'b1) pops2++;
    @(posedge clock);
    if (reset) rem1 = 0;
    else if (p1) begin fb1 = q1.pop_front(); rem1 = FLEN1; end
    else if (rem1 > 0) rem1--;
    if (reset) rem2 = 0;
    else if (p2) begin fb2 = q2.pop_front(); rem2 = FLEN2; end
    else if (rem2 > 0) rem2--;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0; pops1 = 0; pops2 = 0;
    rem1 = 0; rem2 = 0; fb1 = '0; fb2 = '0;
    en1 = 1'b1; en2 = 1'b1;
    reset = 1'b1;
    q1.push_back(8'hA5);
    q2.push_back(8'h80);
    drive();
    @(posedge clock);
    #1;

    // Reset held with FIFO non-empty: no pop, idle line
    run(3);
    reset = 1'b0;

    // Single byte 0xA5 (1 stop) and 0x80 (2 stops)
    run(46);
    check("pops_single1", pops1, 1);
    check("pops_single2", pops2, 1);

    // Back-to-back 0x00, 0xFF
    q1.push_back(8'h00);
    q1.push_back(8'hFF);
    run(85);
    check("pops_b2b", pops1, 3);

    // FIFO blocked for 100 cycles, then released
    en1 = 1'b0;
    q1.push_back(8'h11);
    run(100);
    check("pops_blocked", pops1, 3);
    en1 = 1'b1;
    run(45);
    check("pops_unblocked", pops1, 4);

    // Reset in cycle 15 of a 0x3C frame; 0x5A waits until release
    q1.push_back(8'h3C);
    q1.push_back(8'h5A);
    run(15);
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(45);
    check("pops_reset", pops1, 6);
    check("q_after_reset", q1.size(), 0);

    // Random bytes with the FIFO ready line toggling
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if (q1.size() < 4) q1.push_back(8'($urandom));
        if (q2.size() < 4) q2.push_back(8'($urandom));
      end
      en1 = ($urandom_range(0, 4) != 0);
      en2 = ($urandom_range(0, 4) != 0);
      step();
    end
    en1 = 1'b1;
    en2 = 1'b1;
    run(250);
    check("drained1", q1.size(), 0);
    check("drained2", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
